// File: rtl/vball_pkg.sv
// Shared types, defaults and grant-priority helper for the graphics-ROM arbiter.
// No state of its own; pick_winner is purely combinational.
// No flow control here; the arbiter FSM applies the result only in IDLE.
package vball_pkg;

  localparam int VB_AW       = 18;
  localparam int VB_DW       = 16;
  localparam int VB_MAX_WAIT = 15;
  localparam int VB_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_DL  = 2'd0,
    REQ_BG  = 2'd1,
    REQ_SPR = 2'd2
  } requester_t;

  // Download first, then a starved reader (bg before spr), then the
  // blank-phase preference: active display favours bg, blank favours spr.
  // A stale starved flag is ignored unless the requester is still asking.
  function automatic requester_t pick_winner(
    input logic dl,
    input logic bg,
    input logic spr,
    input logic bg_starved,
    input logic spr_starved,
    input logic hb
  );
    requester_t w;
    if (dl)                       w = REQ_DL;
    else if (bg && bg_starved)    w = REQ_BG;
    else if (spr && spr_starved)  w = REQ_SPR;
    else if (bg && spr)           w = hb ? REQ_SPR : REQ_BG;
    else if (bg)                  w = REQ_BG;
    else                          w = REQ_SPR;
    return w;
  endfunction

endpackage

// File: rtl/vball_starve_cnt.sv
// Saturating wait counter: how long a requester has been asking without a grant.
// starved is a register decode, so it is valid in the same cycle the count lands.
// Cleared by a grant or by dropping req; holds at threshold until then.
module vball_starve_cnt
  import vball_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                grant,
  input  logic [VB_CNT_W-1:0] threshold,
  output logic                starved
);

  logic [VB_CNT_W-1:0] cnt;

  // Count cycles spent asking but not being granted, saturating at threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!req || grant) begin
      cnt <= '0;
    end else if (cnt < threshold) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == threshold);

endmodule

// File: rtl/vball_rom_arbiter.sv
// Shares one graphics-ROM port between download writes, bg reads and sprite reads.
// Latency: grant +1 cycle to mem_req, mem_ack +1 cycle to requester ack, +1 dead cycle.
// Requesters hold req level until their ack; memory holds us in BUSY until mem_ack.
module vball_rom_arbiter
  import vball_pkg::*;
#(
  parameter int AW       = VB_AW,
  parameter int DW       = VB_DW,
  parameter int MAX_WAIT = VB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hb,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_wdata,
  output logic          dl_ack,
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic          bg_ack,
  output logic [DW-1:0] bg_data,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_ack,
  output logic [DW-1:0] spr_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [VB_CNT_W-1:0] THRESH = VB_CNT_W'(MAX_WAIT);

  state_t     state;
  requester_t owner;
  requester_t winner;
  logic       any_req;
  logic       granting;
  logic       grant_bg;
  logic       grant_spr;
  logic       bg_starved;
  logic       spr_starved;

  assign any_req   = dl_req | bg_req | spr_req;
  assign granting  = (state == IDLE) && any_req;
  assign winner    = pick_winner(dl_req, bg_req, spr_req, bg_starved, spr_starved, hb);
  assign grant_bg  = granting && (winner == REQ_BG);
  assign grant_spr = granting && (winner == REQ_SPR);
  assign busy      = (state != IDLE);

  vball_starve_cnt u_bg_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bg_req),
    .grant     (grant_bg),
    .threshold (THRESH),
    .starved   (bg_starved)
  );

  vball_starve_cnt u_spr_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (spr_req),
    .grant     (grant_spr),
    .threshold (THRESH),
    .starved   (spr_starved)
  );

  // Access FSM: latch the winner's request at grant, wait for memory, pulse its ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= REQ_DL;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dl_ack    <= 1'b0;
      bg_ack    <= 1'b0;
      spr_ack   <= 1'b0;
      bg_data   <= '0;
      spr_data  <= '0;
    end else begin
      dl_ack  <= 1'b0;
      bg_ack  <= 1'b0;
      spr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            mem_req   <= 1'b1;
            mem_we    <= (winner == REQ_DL);
            mem_wdata <= (winner == REQ_DL) ? dl_wdata : '0;
            case (winner)
              REQ_DL:  mem_addr <= dl_addr;
              REQ_BG:  mem_addr <= bg_addr;
              default: mem_addr <= spr_addr;
            endcase
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            case (owner)
              REQ_DL: dl_ack <= 1'b1;
              REQ_BG: begin
                bg_ack  <= 1'b1;
                bg_data <= mem_rdata;
              end
              REQ_SPR: begin
                spr_ack  <= 1'b1;
                spr_data <= mem_rdata;
              end
              default: ;
            endcase
          end
        end
        RESP: begin
          // dead cycle lets the served requester drop or advance its req
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vball_rom_arbiter.sv
// Self-checking bench for vball_rom_arbiter: queue-driven requesters, a latency-
// programmable memory, a cycle-level reference model compared every cycle, and
// directed scenarios with hand-computed expectations followed by random batches.
module tb_vball_rom_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          hb = 1'b0;
  logic          dl_req = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [DW-1:0] dl_wdata = '0;
  logic          dl_ack;
  logic          bg_req = 1'b0;
  logic [AW-1:0] bg_addr = '0;
  logic          bg_ack;
  logic [DW-1:0] bg_data;
  logic          spr_req = 1'b0;
  logic [AW-1:0] spr_addr = '0;
  logic          spr_ack;
  logic [DW-1:0] spr_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  vball_rom_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .hb(hb),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_wdata(dl_wdata), .dl_ack(dl_ack),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_data(bg_data),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_data(spr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit checking = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rfun(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {14'd0, a[17:16]};
  endfunction

  // ---------------- memory: ack 'lat' cycles after mem_req first seen ----------------
  int   lat = 1;
  int   wcnt = 0;
  bit   force_en = 1'b0;
  logic [DW-1:0] force_val = '0;
  bit   stray = 1'b0;

  always @(negedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt == lat) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      mem_ack = stray;
    end
    mem_rdata = force_en ? force_val : rfun(mem_addr);
  end

  // ---------------- requesters: hold head of queue until acked ----------------
  logic [AW-1:0] dlq_a[$];
  logic [DW-1:0] dlq_d[$];
  logic [AW-1:0] bgq_a[$];
  logic [AW-1:0] sprq_a[$];
  int gap_dl = 0, gap_bg = 0, gap_spr = 0;
  int gapmax = 0;
  bit rand_hb = 1'b0;

  always @(negedge clk) begin
    #1;
    if (dl_ack && dlq_a.size() > 0) begin
      void'(dlq_a.pop_front());
      void'(dlq_d.pop_front());
      gap_dl = $urandom_range(gapmax);
    end
    if (bg_ack && bgq_a.size() > 0) begin
      void'(bgq_a.pop_front());
      gap_bg = $urandom_range(gapmax);
    end
    if (spr_ack && sprq_a.size() > 0) begin
      void'(sprq_a.pop_front());
      gap_spr = $urandom_range(gapmax);
    end
    if (gap_dl > 0) begin dl_req = 1'b0; gap_dl--; end
    else if (dlq_a.size() > 0) begin dl_req = 1'b1; dl_addr = dlq_a[0]; dl_wdata = dlq_d[0]; end
    else dl_req = 1'b0;
    if (gap_bg > 0) begin bg_req = 1'b0; gap_bg--; end
    else if (bgq_a.size() > 0) begin bg_req = 1'b1; bg_addr = bgq_a[0]; end
    else bg_req = 1'b0;
    if (gap_spr > 0) begin spr_req = 1'b0; gap_spr--; end
    else if (sprq_a.size() > 0) begin spr_req = 1'b1; spr_addr = sprq_a[0]; end
    else spr_req = 1'b0;
    if (rand_hb) hb = 1'($urandom_range(1));
  end

  // ---------------- reference model (access-level phases, integer counters) ----------------
  int            m_phase = 0;   // 0 waiting for requests, 1 access in memory, 2 dead cycle
  int            m_owner = 0;   // 0 dl, 1 bg, 2 spr
  int            m_cnt_bg = 0, m_cnt_spr = 0;
  logic          m_req = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_bgdata = '0, m_sprdata = '0;
  logic          m_dlack = 1'b0, m_bgack = 1'b0, m_sprack = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    int win;
    if (!reset_n) begin
      m_phase = 0; m_owner = 0; m_cnt_bg = 0; m_cnt_spr = 0;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_bgdata = '0; m_sprdata = '0;
      m_dlack = 1'b0; m_bgack = 1'b0; m_sprack = 1'b0;
    end else begin
      win = -1;
      m_dlack = 1'b0; m_bgack = 1'b0; m_sprack = 1'b0;
      if (m_phase == 0) begin
        if (dl_req || bg_req || spr_req) begin
          if (dl_req)                          win = 0;
          else if (bg_req && m_cnt_bg == MW)   win = 1;
          else if (spr_req && m_cnt_spr == MW) win = 2;
          else if (bg_req && spr_req)          win = hb ? 2 : 1;
          else                                 win = bg_req ? 1 : 2;
          m_owner = win;
          m_req   = 1'b1;
          m_we    = (win == 0);
          m_addr  = (win == 0) ? dl_addr : (win == 1) ? bg_addr : spr_addr;
          m_wdata = (win == 0) ? dl_wdata : '0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (mem_ack) begin
          m_req = 1'b0;
          m_phase = 2;
          if (m_owner == 0) m_dlack = 1'b1;
          else if (m_owner == 1) begin m_bgack = 1'b1; m_bgdata = mem_rdata; end
          else begin m_sprack = 1'b1; m_sprdata = mem_rdata; end
        end
      end else begin
        m_phase = 0;
      end
      m_cnt_bg  = (!bg_req || win == 1) ? 0 : ((m_cnt_bg < MW) ? m_cnt_bg + 1 : MW);
      m_cnt_spr = (!spr_req || win == 2) ? 0 : ((m_cnt_spr < MW) ? m_cnt_spr + 1 : MW);
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    logic [127:0] a, e;
    if (checking) begin
      a = 128'({mem_req, busy, dl_ack, bg_ack, spr_ack, bg_data, spr_data,
                m_req ? {mem_we, mem_addr} : 19'd0, (m_req && m_we) ? mem_wdata : 16'd0});
      e = 128'({m_req, (m_phase != 0), m_dlack, m_bgack, m_sprack, m_bgdata, m_sprdata,
                m_req ? {m_we, m_addr} : 19'd0, (m_req && m_we) ? m_wdata : 16'd0});
      check("cycle_vs_model", a, e);
    end
  end

  // ---------------- monitor: grant log, ack counts, timestamps ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            cyc;
  } glog_t;
  glog_t glog[$];
  logic prev_req = 1'b0, prev_busy = 1'b0;
  int n_dlack = 0, n_bgack = 0, n_sprack = 0;
  int mack_cyc = -1, bgack_cyc = -1, busyfall_cyc = -1;

  always @(posedge clk) begin
    if (mem_ack && mem_req) mack_cyc = cyc;
    cyc++;
  end

  always @(negedge clk) begin
    glog_t g;
    if (mem_req && !prev_req) begin
      g.addr = mem_addr; g.we = mem_we; g.wdata = mem_wdata; g.cyc = cyc;
      glog.push_back(g);
    end
    prev_req = mem_req;
    if (dl_ack) n_dlack++;
    if (bg_ack) begin n_bgack++; bgack_cyc = cyc; end
    if (spr_ack) n_sprack++;
    if (prev_busy && !busy) busyfall_cyc = cyc;
    prev_busy = busy;
  end

  task automatic drain(input string nm);
    int n = 0;
    while ((dlq_a.size() + bgq_a.size() + sprq_a.size() > 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain_timeout"}, 128'(n < 2000), 128'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_memreq(input string nm);
    int n = 0;
    while (!mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_memreq_timeout"}, 128'(n < 100), 128'(1));
  endtask

  function automatic int find_addr(input logic [AW-1:0] a);
    for (int i = 0; i < glog.size(); i++)
      if (glog[i].addr == a) return i;
    return -1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, b0, s0, pd, pb, ps, nb;

    // reset values while reset_n is held low
    repeat (2) @(negedge clk);
    check("reset_outputs",
          128'({mem_req, mem_we, mem_addr, mem_wdata, dl_ack, bg_ack, spr_ack, bg_data, spr_data, busy}),
          128'(0));
    reset_n = 1'b1;
    checking = 1'b1;
    repeat (2) @(negedge clk);

    // single bg read, memory acks 2 cycles after mem_req with 0xBEEF
    hb = 1'b0; lat = 2; force_en = 1'b1; force_val = 16'hBEEF;
    glog.delete();
    bgq_a.push_back(18'h01234);
    drain("single");
    check("single_grants", 128'(glog.size()), 128'(1));
    check("single_addr", 128'(glog[0].addr), 128'(18'h01234));
    check("single_we", 128'(glog[0].we), 128'(0));
    check("single_bg_data", 128'(bg_data), 128'(16'hBEEF));
    check("single_mack_lat", 128'(mack_cyc - glog[0].cyc), 128'(2));
    check("single_ack_after_mack", 128'(bgack_cyc - mack_cyc), 128'(1));
    check("single_busy_fall", 128'(busyfall_cyc - mack_cyc), 128'(2));
    force_en = 1'b0;

    // phase priority with hb=0: bg first, spr immediately after RESP
    lat = 1; hb = 1'b0; glog.delete();
    bgq_a.push_back(18'h00100);
    sprq_a.push_back(18'h00200);
    drain("phase0");
    check("phase0_first", 128'(glog[0].addr), 128'(18'h00100));
    check("phase0_second", 128'(glog[1].addr), 128'(18'h00200));
    check("phase0_gap", 128'(glog[1].cyc - glog[0].cyc), 128'(4));

    // phase priority with hb=1: spr first
    hb = 1'b1; glog.delete();
    bgq_a.push_back(18'h00100);
    sprq_a.push_back(18'h00200);
    drain("phase1");
    check("phase1_first", 128'(glog[0].addr), 128'(18'h00200));
    check("phase1_second", 128'(glog[1].addr), 128'(18'h00100));
    check("phase1_gap", 128'(glog[1].cyc - glog[0].cyc), 128'(4));

    // download beats bg regardless of phase
    hb = 1'b0; glog.delete(); d0 = n_dlack;
    dlq_a.push_back(18'h00010); dlq_d.push_back(16'h5A5A);
    bgq_a.push_back(18'h00020);
    drain("dl");
    check("dl_first_addr", 128'(glog[0].addr), 128'(18'h00010));
    check("dl_first_we", 128'(glog[0].we), 128'(1));
    check("dl_first_wdata", 128'(glog[0].wdata), 128'(16'h5A5A));
    check("dl_then_bg", 128'({glog[1].we, glog[1].addr}), 128'({1'b0, 18'h00020}));
    check("dl_ack_count", 128'(n_dlack - d0), 128'(1));

    // starvation: spr has phase priority and keeps asking; bg must get in once its count hits 15
    hb = 1'b1; lat = 1; glog.delete();
    for (int i = 0; i < 8; i++) sprq_a.push_back(18'(18'h00800 + i));
    bgq_a.push_back(18'h00333);
    drain("starve");
    check("starve_bg_index", 128'(find_addr(18'h00333)), 128'(4));

    // hb rises while bg is in flight; next contested grant uses the blank priority
    hb = 1'b0; lat = 3; glog.delete();
    bgq_a.push_back(18'h00400);
    wait_memreq("hbtog");
    hb = 1'b1;
    sprq_a.push_back(18'h00500);
    bgq_a.push_back(18'h00401);
    drain("hbtog");
    check("hbtog_first", 128'(glog[0].addr), 128'(18'h00400));
    check("hbtog_bg_data", 128'(bg_data), 128'(rfun(18'h00401)));
    check("hbtog_second", 128'(glog[1].addr), 128'(18'h00500));
    check("hbtog_third", 128'(glog[2].addr), 128'(18'h00401));

    // memory acks in the very cycle mem_req first rises
    lat = 0; glog.delete(); s0 = n_sprack;
    sprq_a.push_back(18'h00600);
    drain("sameack");
    check("sameack_count", 128'(n_sprack - s0), 128'(1));
    check("sameack_data", 128'(spr_data), 128'(16'hA3C3));
    check("sameack_cycle", 128'(mack_cyc - glog[0].cyc), 128'(0));

    // async reset in the middle of an access, then a stray mem_ack
    lat = 20; hb = 1'b0; glog.delete();
    bgq_a.push_back(18'h00700);
    wait_memreq("rst");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    bgq_a.delete();
    bg_req = 1'b0;
    nb = n_bgack;
    #1;
    check("rst_outputs_now",
          128'({mem_req, mem_we, mem_addr, mem_wdata, dl_ack, bg_ack, spr_ack, bg_data, spr_data, busy}),
          128'(0));
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    #2;
    stray = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_ack", 128'(n_bgack - nb), 128'(0));
    check("rst_idle", 128'({mem_req, busy}), 128'(0));
    check("rst_no_new_grant", 128'(glog.size()), 128'(1));

    // random batches against the model
    rand_hb = 1'b1; gapmax = 2;
    d0 = n_dlack; b0 = n_bgack; s0 = n_sprack;
    pd = 0; pb = 0; ps = 0;
    for (int bt = 0; bt < 8; bt++) begin
      int nd, nbg, nsp;
      lat = $urandom_range(4);
      nd = $urandom_range(2); nbg = $urandom_range(6); nsp = $urandom_range(6);
      for (int i = 0; i < nd; i++) begin
        dlq_a.push_back(18'($urandom)); dlq_d.push_back(16'($urandom));
      end
      for (int i = 0; i < nbg; i++) bgq_a.push_back(18'($urandom));
      for (int i = 0; i < nsp; i++) sprq_a.push_back(18'($urandom));
      pd += nd; pb += nbg; ps += nsp;
      drain("random");
    end
    rand_hb = 1'b0;
    check("random_dl_acks", 128'(n_dlack - d0), 128'(pd));
    check("random_bg_acks", 128'(n_bgack - b0), 128'(pb));
    check("random_spr_acks", 128'(n_sprack - s0), 128'(ps));

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vball_rom_arbiter.md
# vball_rom_arbiter

Shares the single graphics ROM port among three requesters:
- ROM download (`dl`), which writes;
- background tile fetcher (`bg`);
- sprite fetcher (`spr`).

It sits between the video-timing block and the SDRAM/BRAM ROM controller. Priority between `bg` and `spr` follows the horizontal-blank phase, and per-requester starvation counters guarantee forward progress.

## Interface
Parameters:
- AW, 18, ROM word-address width
- DW, 16, ROM data width
- MAX_WAIT, 15, starvation threshold in cycles (fits in 4 bits)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- hb  in  1  horizontal blank from video timing; 1 = blank
- dl_req  in  1  download write request (level)
- dl_addr  in  AW  download address
- dl_wdata  in  DW  download write data
- dl_ack  out  1  one-cycle pulse: write done
- bg_req  in  1  background read request (level)
- bg_addr  in  AW  background address
- bg_ack  out  1  one-cycle pulse: bg_data valid
- bg_data  out  DW  background read data, held until next bg_ack
- spr_req  in  1  sprite read request (level)
- spr_addr  in  AW  sprite address
- spr_ack  out  1  one-cycle pulse: spr_data valid
- spr_data  out  DW  sprite read data, held until next spr_ack
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = write (dl), 0 = read
- mem_addr  out  AW  memory address, registered at grant
- mem_wdata  out  DW  memory write data, registered at grant
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  DW  read data, valid with mem_ack
- busy  out  1  1 whenever state != IDLE

## Operation
States: IDLE, BUSY, RESP.

IDLE:
- If any request is high, grant one requester.
- Register addr, wdata and we.
- Set mem_req=1 and go to BUSY.
- mem_ack is ignored in IDLE.

Grant priority:
1. dl always wins.
2. Otherwise, a starved requester (wait count == MAX_WAIT) wins; if both are starved, bg wins.
3. Otherwise, when hb=0, bg beats spr; when hb=1, spr beats bg.

BUSY:
- Hold mem_req, mem_addr, mem_we and mem_wdata stable until mem_ack.
- On mem_ack: clear mem_req.
- For bg or spr, capture mem_rdata into that requester's data register.
- Pulse that requester's ack and go to RESP.

RESP:
- One dead cycle so the requester can drop or update req.
- Go to IDLE unconditionally.

Starvation counters (bg and spr, 4 bits each):
- Increment each cycle the requester's req=1 and it is not granted that cycle.
- Saturate at MAX_WAIT.
- Clear on grant, or while req=0.
- dl has no counter.

Other rules:
- hb is sampled only at grant. Changes during BUSY/RESP do not affect the in-flight access.
- A requester holds req, addr and wdata stable from req assertion until its ack. It must deassert req or present the next address by the cycle after its ack.

## Timing
- Reset (asynchronous): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; all acks=0; bg_data=0, spr_data=0; counters=0; busy=0.
- Grant latency: req sampled high in IDLE at edge N gives mem_req=1 in cycle N+1.
- Completion: mem_ack at edge K gives mem_req=0 and x_ack=1 (with data valid) in cycle K+1, plus RESP in cycle K+1.
- State returns to IDLE in cycle K+2. The earliest next mem_req is cycle K+3.
- Maximum throughput: one access per (memory latency + 3) cycles.
- Simultaneous dl/bg/spr requests in IDLE: exactly one grant. The losers' counters increment.
- Reset asserted mid-BUSY: mem_req drops immediately and no ack is issued. A late mem_ack after reset is ignored.
- mem_ack arriving in the same cycle mem_req first rises is legal and is honoured.

## Structure
- Shared package `vball_pkg`, holding:
  - state enum {IDLE, BUSY, RESP};
  - requester enum {REQ_DL, REQ_BG, REQ_SPR};
  - default AW/DW constants.
- One sub-module `vball_starve_cnt`: saturating 4-bit wait counter with inputs req, grant and threshold, and output starved. Instantiated twice (bg, spr).
- Grant logic and the FSM live in the top module.

## Test plan
- **Single bg read:** hb=0, bg_req with addr 0x01234; memory acks 2 cycles after mem_req with 0xBEEF.
  - Required: mem_addr=0x01234, mem_we=0; bg_ack one cycle after mem_ack; bg_data=0xBEEF; busy falls 2 cycles after mem_ack.
- **Phase priority:** bg_req and spr_req simultaneous.
  - With hb=0: bg is granted first.
  - Repeated with hb=1: spr is granted first.
  - The loser is served immediately after the winner's RESP.
- **dl precedence:** dl_req and bg_req simultaneous with hb=0; dl_addr 0x00010, dl_wdata 0x5A5A.
  - Required: write granted first with mem_we=1 and mem_wdata=0x5A5A; dl_ack pulses; bg is served next.
- **Starvation:** hb=1, spr_req held continuously, bg_req held, memory latency 1.
  - Required: bg is granted no later than when its counter hits 15, even though spr has phase priority.
- **Async reset mid-BUSY:** reset_n low for 1 cycle while mem_req=1, then mem_ack arrives.
  - Required: all outputs zero immediately; no ack pulse; state IDLE; the stray mem_ack is ignored.
- **hb toggle in flight:** grant bg at hb=0, then raise hb during BUSY.
  - Required: bg completes normally; the next grant uses hb=1 priority.
